// File: rtl/pixel_box_filter_if.sv
// Filter-side bundle between the Controller (master) and the box filter (slave).
interface pixel_box_filter_if #(
  parameter int DATA_WIDTH = 24
);
  logic                  Filter_EN;
  logic [DATA_WIDTH-1:0] Filter_DIN;
  logic                  Filter_CLR;
  logic [DATA_WIDTH-1:0] Filter_DATA;
  logic                  Filter_DNE;
  logic                  Filter_BSY;

  modport master (
    output Filter_EN, Filter_DIN, Filter_CLR,
    input  Filter_DATA, Filter_DNE, Filter_BSY
  );

  modport slave (
    input  Filter_EN, Filter_DIN, Filter_CLR,
    output Filter_DATA, Filter_DNE, Filter_BSY
  );
endinterface

// File: rtl/pixel_box_filter.sv
// Per-channel moving average over the last 2**TAP_LOG2 RGB888 samples; DNE 4 cycles after EN, EN ignored while BSY.
// Define PIXEL_BOX_FILTER_ROUND_EN for round-half-up results instead of truncation.
module pixel_box_filter #(
  parameter int DATA_WIDTH = 24,
  parameter int CH_WIDTH   = 8,
  parameter int TAP_LOG2   = 2
) (
  input  logic              Filter_CLK,
  input  logic              Filter_RST,
  pixel_box_filter_if.slave flt
);
  localparam int TAPS = 2 ** TAP_LOG2;
`ifdef PIXEL_BOX_FILTER_ROUND_EN
  localparam int SUM_W = CH_WIDTH + TAP_LOG2 + 1;
`else
  localparam int SUM_W = CH_WIDTH + TAP_LOG2;
`endif

  typedef enum logic [2:0] {IDLE, CALC_R, CALC_G, CALC_B, DONE} state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] hist_q [TAPS];
  logic [DATA_WIDTH-1:0] res_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  dne_q;
  logic                  bsy_q;

  logic [1:0]            ch_sel_d;
  logic [SUM_W-1:0]      sum_d;
  logic [CH_WIDTH-1:0]   avg_d;

  // The single adder tree follows the state: R, then G, then B.
  always_comb begin
    ch_sel_d = 2'd0;
    case (state_q)
      CALC_R:  ch_sel_d = 2'd2;
      CALC_G:  ch_sel_d = 2'd1;
      default: ch_sel_d = 2'd0;
    endcase
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < TAPS; i++) begin
      sum_d = sum_d + SUM_W'(hist_q[i][ch_sel_d*CH_WIDTH +: CH_WIDTH]);
    end
  end

`ifdef PIXEL_BOX_FILTER_ROUND_EN
  logic [SUM_W-1:0] rnd_d;

  always_comb begin
    rnd_d = (sum_d + SUM_W'(TAPS / 2)) >> TAP_LOG2;
    avg_d = (rnd_d[SUM_W-1:CH_WIDTH] != '0) ? '1 : rnd_d[CH_WIDTH-1:0];
  end
`else
  assign avg_d = CH_WIDTH'(sum_d >> TAP_LOG2);
`endif

  always_ff @(posedge Filter_CLK) begin
    if (Filter_RST) begin
      state_q <= IDLE;
      for (int i = 0; i < TAPS; i++) begin
        hist_q[i] <= '0;
      end
      res_q  <= '0;
      data_q <= '0;
      dne_q  <= 1'b0;
      bsy_q  <= 1'b0;
    end else begin
      dne_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (flt.Filter_EN) begin
            // CLR with EN: the new sample lands in an otherwise empty window.
            hist_q[0] <= flt.Filter_DIN;
            for (int i = 1; i < TAPS; i++) begin
              hist_q[i] <= flt.Filter_CLR ? '0 : hist_q[i-1];
            end
            state_q <= CALC_R;
            bsy_q   <= 1'b1;
          end else if (flt.Filter_CLR) begin
            for (int i = 0; i < TAPS; i++) begin
              hist_q[i] <= '0;
            end
          end
        end
        CALC_R: begin
          res_q[2*CH_WIDTH +: CH_WIDTH] <= avg_d;
          state_q <= CALC_G;
        end
        CALC_G: begin
          res_q[CH_WIDTH +: CH_WIDTH] <= avg_d;
          state_q <= CALC_B;
        end
        CALC_B: begin
          res_q[CH_WIDTH-1:0] <= avg_d;
          data_q  <= {res_q[DATA_WIDTH-1:CH_WIDTH], avg_d};
          dne_q   <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
          bsy_q   <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          bsy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign flt.Filter_DATA = data_q;
  assign flt.Filter_DNE  = dne_q;
  assign flt.Filter_BSY  = bsy_q;
endmodule

// File: doc/pixel_box_filter.md
Name: pixel_box_filter

Overview:
- Filter stage driven directly by the Controller: consumes its filter-enable pulse and returns the filter-done pulse plus the 24-bit filtered pixel on the Controller's FDNE/FDATA inputs.
- Keeps a sliding window of the last 2**TAP_LOG2 RGB888 samples and outputs the per-channel box (moving) average.
- Uses one shared adder tree, sequenced over R, G, B in successive cycles to keep area small.

Parameters:
- DATA_WIDTH, 24, pixel width; must equal 3*CH_WIDTH.
- CH_WIDTH, 8, width of one colour channel.
- TAP_LOG2, 2, log2 of window depth; TAPS = 2**TAP_LOG2; legal range 1..3.

Ports:
- Filter_CLK  in  1  system clock; all logic is on the rising edge.
- Filter_RST  in  1  synchronous, active-high reset.
- Filter_EN  in  1  one-cycle start pulse from the Controller (its FEN); qualifies Filter_DIN.
- Filter_DIN  in  DATA_WIDTH  input pixel; R=[23:16], G=[15:8], B=[7:0].
- Filter_CLR  in  1  clears the window history.
- Filter_DATA  out  DATA_WIDTH  filtered pixel, registered, same packing as Filter_DIN (Controller FDATA).
- Filter_DNE  out  1  one-cycle result-valid pulse (Controller FDNE).
- Filter_BSY  out  1  high while a sample is being processed.

Behaviour:
- Reset: synchronous, active-high on Filter_RST, sampled on the Filter_CLK rising edge.
  - State goes to IDLE; all TAPS history entries become 0.
  - Filter_DATA=0, Filter_DNE=0, Filter_BSY=0.
  - Reset overrides every other input, including mid-operation; any in-flight result is discarded and no DNE is issued.
- States: IDLE, CALC_R, CALC_G, CALC_B, DONE.
- IDLE:
  - On edge k with Filter_EN=1, shift Filter_DIN into history slot 0 (oldest sample drops out) and go to CALC_R.
  - Otherwise stay in IDLE.
- CALC_R / CALC_G / CALC_B:
  - Each state sums the TAPS samples of one channel into a CH_WIDTH+TAP_LOG2-bit unsigned result (no overflow possible).
  - Each state shifts the sum right by TAP_LOG2 (truncate) into the matching channel of an internal result register.
  - Transitions are unconditional: CALC_R -> CALC_G -> CALC_B -> DONE.
- DONE entry (edge k+3): Filter_DATA loads the full 24-bit result.
- DONE: Filter_DNE=1 for exactly this one cycle, then unconditionally return to IDLE at edge k+4.
- Latency: DNE is high in the cycle after edge k+3, i.e. 4 cycles after the accepting edge. Throughput is one sample per 5 cycles.
- Filter_BSY is 1 in CALC_R, CALC_G, CALC_B and DONE; 0 in IDLE.
- Filter_DATA holds its value between results; it changes only on DONE entry or on reset.
- Filter_EN outside IDLE is ignored: no queueing, no history update, no extra DNE.
- Filter_CLR:
  - Honoured only in IDLE; ignored while busy.
  - CLR alone zeroes the history; Filter_DATA is unchanged.
  - CLR and EN in the same IDLE cycle: clear first, then insert the sample, so the window becomes {DIN, 0, ...}.
- Warm-up: the window starts zero-filled, so the first TAPS-1 results after reset or CLR average in zeros. This is intended.
- History is a shift register of TAPS x DATA_WIDTH bits; no wrap-around pointer.

Optional Feature:
- Macro: PIXEL_BOX_FILTER_ROUND_EN.
- Defined: each channel result is (sum + 2**(TAP_LOG2-1)) >> TAP_LOG2, i.e. round-half-up. The adder is widened by one bit; results saturate at 2**CH_WIDTH-1, which cannot be exceeded anyway.
- Undefined: plain truncation, (sum >> TAP_LOG2).
- Latency, handshake and state sequence are identical in both builds.

Test Plan:
- Reset, then one EN with DIN=0xFF8040 (TAP_LOG2=2) -> DNE pulses exactly 4 cycles after the accepting edge.
  - Truncate build: Filter_DATA=0x3F2010.
  - ROUND_EN build: Filter_DATA=0x402010.
  - BSY is high for exactly 4 cycles.
- Four EN pulses with DIN=0x102030, spaced 5 cycles apart -> results 0x04080C, 0x081018, 0x0C1824, then 0x102030. DATA is held between results.
- EN re-asserted on every cycle while BSY=1 -> exactly one DNE per accepted sample; the history contains only accepted samples, checked via the next result.
- After the window is filled with 0xFFFFFF, assert CLR and EN together with DIN=0x400000 -> DATA=0x100000 (truncate).
- Filter_RST asserted during CALC_G -> next cycle DATA=0, DNE=0, BSY=0, state IDLE, no DNE afterwards. A subsequent EN with 0x808080 gives 0x202020.
- Controller integration: drive Controller_STRT, with Controller FEN->Filter_EN and Filter_DNE/Filter_DATA->FDNE/FDATA -> the Controller receives one FDNE per FEN and completes with DNE=1, with no lost or duplicated handshakes.
